intersection_sequencer: RTL and testbench

Actuated two-road intersection sequencer with optional pedestrian phase. It drives the 2-bit light codes for road A and road B from per-road vehicle detectors, replacing the fixed 120-cycle timetable with demand-driven phases. It adds minimum and maximum green limits, an all-red clearance and a safe reset state. It sits between the detector/button inputs and the lamp drivers.

---
 rtl/intersection_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_intersection_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_sequencer.sv
// Actuated two-road intersection sequencer: demand-driven greens with min/max limits,
// yellow and all-red clearance; pedestrian phase is built only with INTERSECTION_PED_EN.
module intersection_sequencer #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       det_a,
  input  logic       det_b,
  input  logic       ped_req,
  output logic [1:0] roadA,
  output logic [1:0] roadB,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_A_GRN = 3'd0,
    ST_A_YEL = 3'd1,
    ST_AR_AB = 3'd2,
    ST_B_GRN = 3'd3,
    ST_B_YEL = 3'd4,
    ST_AR_BA = 3'd5,
    ST_PED   = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_GREEN  = 2'b11;

  localparam int MAX_GY  = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
  localparam int MAX_GYA = (MAX_GY > ALLRED_T) ? MAX_GY : ALLRED_T;
  localparam int MAX_ALL = (MAX_GYA > WALK_T) ? MAX_GYA : WALK_T;
  localparam int TW      = $clog2(MAX_ALL + 1);

  localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YEL = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR  = TW'(ALLRED_T - 1);

  state_t          state_r;
  state_t          state_next_s;
  logic [TW-1:0]   timer_r;
  logic [TW-1:0]   timer_next_s;
  logic            pend_a_r;
  logic            pend_b_r;
  logic            pend_p_s;
  logic [1:0]      lamp_a_s;
  logic [1:0]      lamp_b_s;
  logic            walk_s;

`ifdef INTERSECTION_PED_EN
  localparam logic [TW-1:0] T_WALK = TW'(WALK_T - 1);
  logic pend_p_r;
  logic from_a_r;
  assign pend_p_s = pend_p_r;
`else
  // Pedestrian input is intentionally ignored in this build.
  assign pend_p_s = ped_req & 1'b0;
`endif

  // Next-state selection from dwell timer, pending demand and detector levels.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_A_GRN: begin
        if ((timer_r >= T_MIN) && (pend_b_r || pend_p_s) && (!det_a || (timer_r == T_MAX)))
          state_next_s = ST_A_YEL;
        else
          state_next_s = state_r;
      end
      ST_A_YEL: begin
        if (timer_r == T_YEL) state_next_s = ST_AR_AB;
        else                  state_next_s = state_r;
      end
      ST_AR_AB: begin
        if (timer_r == T_AR) state_next_s = pend_p_s ? ST_PED : ST_B_GRN;
        else                 state_next_s = state_r;
      end
      ST_B_GRN: begin
        if ((timer_r >= T_MIN) && (pend_a_r || pend_p_s) && (!det_b || (timer_r == T_MAX)))
          state_next_s = ST_B_YEL;
        else
          state_next_s = state_r;
      end
      ST_B_YEL: begin
        if (timer_r == T_YEL) state_next_s = ST_AR_BA;
        else                  state_next_s = state_r;
      end
      ST_AR_BA: begin
        if (timer_r == T_AR) state_next_s = pend_p_s ? ST_PED : ST_A_GRN;
        else                 state_next_s = state_r;
      end
`ifdef INTERSECTION_PED_EN
      ST_PED: begin
        if (timer_r == T_WALK) state_next_s = from_a_r ? ST_B_GRN : ST_A_GRN;
        else                   state_next_s = state_r;
      end
`endif
      default: state_next_s = ST_A_GRN;
    endcase
  end

  // Dwell timer restarts on every phase change and saturates at the max-green mark.
  always_comb begin
    timer_next_s = timer_r;
    if (state_next_s != state_r)
      timer_next_s = '0;
    else if (timer_r == T_MAX)
      timer_next_s = timer_r;
    else
      timer_next_s = timer_r + 1'b1;
  end

  // Lamp decode of the upcoming state so the registered outputs track the state register.
  always_comb begin
    lamp_a_s = LAMP_RED;
    lamp_b_s = LAMP_RED;
    walk_s   = 1'b0;
    case (state_next_s)
      ST_A_GRN: lamp_a_s = LAMP_GREEN;
      ST_A_YEL: lamp_a_s = LAMP_YELLOW;
      ST_B_GRN: lamp_b_s = LAMP_GREEN;
      ST_B_YEL: lamp_b_s = LAMP_YELLOW;
`ifdef INTERSECTION_PED_EN
      ST_PED:   walk_s   = 1'b1;
`endif
      default: begin
        lamp_a_s = LAMP_RED;
        lamp_b_s = LAMP_RED;
      end
    endcase
  end

  // State, timer, vehicle demand latches and registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_A_GRN;
      timer_r  <= '0;
      pend_a_r <= 1'b0;
      pend_b_r <= 1'b0;
      roadA    <= LAMP_GREEN;
      roadB    <= LAMP_RED;
      walk     <= 1'b0;
      phase    <= 3'd0;
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
      // Entering the served green clears demand, even if the detector is still set.
      if ((state_next_s == ST_A_GRN) && (state_r != ST_A_GRN)) pend_a_r <= 1'b0;
      else if (det_a && (state_r != ST_A_GRN))                pend_a_r <= 1'b1;
      else                                                     pend_a_r <= pend_a_r;
      if ((state_next_s == ST_B_GRN) && (state_r != ST_B_GRN)) pend_b_r <= 1'b0;
      else if (det_b && (state_r != ST_B_GRN))                pend_b_r <= 1'b1;
      else                                                     pend_b_r <= pend_b_r;
      roadA <= lamp_a_s;
      roadB <= lamp_b_s;
      walk  <= walk_s;
      phase <= state_next_s;
    end
  end

`ifdef INTERSECTION_PED_EN
  // Pedestrian demand latch and record of which road yielded to the walk phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p_r <= 1'b0;
      from_a_r <= 1'b0;
    end else begin
      if ((state_next_s == ST_PED) && (state_r != ST_PED)) pend_p_r <= 1'b0;
      else if (ped_req && (state_r != ST_PED))            pend_p_r <= 1'b1;
      else                                                 pend_p_r <= pend_p_r;
      if ((state_r == ST_AR_AB) && (state_next_s == ST_PED))      from_a_r <= 1'b1;
      else if ((state_r == ST_AR_BA) && (state_next_s == ST_PED)) from_a_r <= 1'b0;
      else                                                        from_a_r <= from_a_r;
    end
  end
`endif

endmodule

// File: tb/tb_intersection_sequencer.sv
// Self-checking bench for intersection_sequencer: directed phase-timing scenarios plus a
// randomized run compared cycle by cycle against a rule-level reference model.
module tb_intersection_sequencer;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL   = 2;
  localparam int AR    = 1;
  localparam int WLK   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       det_a = 1'b0;
  logic       det_b = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] roadA;
  logic [1:0] roadB;
  logic       walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: phase number, cycles spent in it, pending demand, who yielded
  int   mph, mel;
  logic mpa, mpb, mpp, mfa;

  intersection_sequencer #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL), .ALLRED_T(AR), .WALK_T(WLK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .det_a(det_a), .det_b(det_b), .ped_req(ped_req),
    .roadA(roadA), .roadB(roadB), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] lamp_a(input int ph);
    return (ph == 0) ? 2'b11 : (ph == 1) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [1:0] lamp_b(input int ph);
    return (ph == 3) ? 2'b11 : (ph == 4) ? 2'b10 : 2'b00;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; det_a = 1'b0; det_b = 1'b0; ped_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_state(input string name, input int exp_ph);
    n_checks++;
    if (phase !== 3'(exp_ph)) $display("FAIL %s phase: got %0d expected %0d", name, phase, exp_ph);
    else n_pass++;
    n_checks++;
    if (roadA !== lamp_a(exp_ph)) $display("FAIL %s roadA: got %b expected %b", name, roadA, lamp_a(exp_ph));
    else n_pass++;
    n_checks++;
    if (roadB !== lamp_b(exp_ph)) $display("FAIL %s roadB: got %b expected %b", name, roadB, lamp_b(exp_ph));
    else n_pass++;
    n_checks++;
    if (walk !== (exp_ph == 6)) $display("FAIL %s walk: got %b expected %b", name, walk, (exp_ph == 6));
    else n_pass++;
  endtask

  task automatic model_step(input logic da, input logic db, input logic pr);
    int nxt;
    nxt = mph;
    case (mph)
      0: if (mel >= MIN_G - 1 && (mpb || mpp) && (!da || mel >= MAX_G - 1)) nxt = 1;
      1: if (mel == YEL - 1) nxt = 2;
      2: if (mel == AR - 1) begin nxt = mpp ? 6 : 3; if (mpp) mfa = 1'b1; end
      3: if (mel >= MIN_G - 1 && (mpa || mpp) && (!db || mel >= MAX_G - 1)) nxt = 4;
      4: if (mel == YEL - 1) nxt = 5;
      5: if (mel == AR - 1) begin nxt = mpp ? 6 : 0; if (mpp) mfa = 1'b0; end
      6: if (mel == WLK - 1) nxt = mfa ? 3 : 0;
      default: nxt = 0;
    endcase
    if (da && mph != 0) mpa = 1'b1;
    if (nxt == 0 && mph != 0) mpa = 1'b0;
    if (db && mph != 3) mpb = 1'b1;
    if (nxt == 3 && mph != 3) mpb = 1'b0;
`ifdef INTERSECTION_PED_EN
    if (pr && mph != 6) mpp = 1'b1;
    if (nxt == 6 && mph != 6) mpp = 1'b0;
`else
    if (pr) mpp = 1'b0;
`endif
    mel = (nxt != mph) ? 0 : mel + 1;
    mph = nxt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_state("reset_hold", 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rest_green();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      n_checks++;
      if (phase !== 3'd0 || roadA !== 2'b11)
        $display("FAIL rest_green cycle %0d: phase=%0d roadA=%b expected phase=0 roadA=11", c, phase, roadA);
      else n_pass++;
      det_a = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic test_min_green();
    int exp_ph[8] = '{0, 0, 0, 0, 1, 1, 2, 3};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      check_state($sformatf("min_green c%0d", c), exp_ph[c]);
      det_b = 1'b1;
      if (c < 7) @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    // continues from test_min_green, resting in B green
    @(negedge clk);
    check_state("pre_async_reset", 3);
    #2 rst_n = 1'b0;
    #1 check_state("async_reset", 0);
    det_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max_green();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      n_checks++;
      if (phase !== ((c < 10) ? 3'd0 : 3'd1))
        $display("FAIL max_green c%0d phase: got %0d expected %0d", c, phase, (c < 10) ? 0 : 1);
      else n_pass++;
      det_a = 1'b1;
      det_b = (c == 1);
      @(negedge clk);
    end
    det_a = 1'b0; det_b = 1'b0;
  endtask

  task automatic test_pedestrian();
    int exp_ph[$];
    repeat (4) exp_ph.push_back(0);
    repeat (2) exp_ph.push_back(1);
    exp_ph.push_back(2);
`ifdef INTERSECTION_PED_EN
    repeat (3) exp_ph.push_back(6);
`endif
    repeat (3) exp_ph.push_back(3);
    do_reset();
    for (int c = 0; c < exp_ph.size(); c++) begin
      check_state($sformatf("pedestrian c%0d", c), exp_ph[c]);
      det_b   = (c == 1);
      ped_req = (c == 1);
      @(negedge clk);
    end
    det_b = 1'b0; ped_req = 1'b0;
  endtask

  task automatic test_random_safety();
    logic safe;
    do_reset();
    mph = 0; mel = 0; mpa = 1'b0; mpb = 1'b0; mpp = 1'b0; mfa = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      check_state($sformatf("random c%0d", c), mph);
      safe = !(roadA != 2'b00 && roadB != 2'b00) && (!walk || (roadA == 2'b00 && roadB == 2'b00));
      n_checks++;
      if (safe !== 1'b1) $display("FAIL safety c%0d: roadA=%b roadB=%b walk=%b", c, roadA, roadB, walk);
      else n_pass++;
      det_a   = ($urandom_range(0, 3) == 0);
      det_b   = ($urandom_range(0, 3) == 0);
      ped_req = ($urandom_range(0, 15) == 0);
      model_step(det_a, det_b, ped_req);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rest_green();
    test_min_green();
    test_async_reset();
    test_max_green();
    test_pedestrian();
    test_random_safety();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
